// File: rtl/uart_rx_if.sv
// uart_rx serial-in / byte-out bundle: the receiver uses the slave modport,
// and the consumer (board glue or testbench) uses the master modport.
interface uart_rx_if;
  logic       RX_serial;
  logic [7:0] RX_byte;
  logic       RX_DV;
  logic       framing_err;
  logic       busy;

  modport master (output RX_serial, input RX_byte, RX_DV, framing_err, busy);
  modport slave  (input RX_serial, output RX_byte, RX_DV, framing_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-cycle RX_DV strobe and framing-error detection.
// Optional macro UART_RX_MAJORITY_EN: each sample is a 2-of-3 vote, and decisions come one cycle later.
module uart_rx #(
  parameter int CLKS_PER_BIT      = 217,
  parameter int HALF_CLKS_PER_BIT = 108
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_LAG = 1;
`else
  localparam int SAMPLE_LAG = 0;
`endif

  localparam logic [CW-1:0] START_PT = CW'(HALF_CLKS_PER_BIT + SAMPLE_LAG);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s;
  logic [CW-1:0] count;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    rx_byte_q;
  logic          rx_dv_q, framing_err_q;
  logic          sample;
  logic          start_pt, bit_end;
  logic          take_bit, stop_ok, stop_bad, busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx.RX_serial;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two-deep history of rx_s: when count reaches START_PT (one cycle past the
  // nominal point), rx_d2/rx_d1/rx_s hold the values at sample point -1/0/+1.
  logic rx_d1, rx_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  always_comb sample = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
`else
  always_comb sample = rx_s;
`endif

  always_comb begin
    start_pt = (count == START_PT);
    bit_end  = (count == BIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (!rx_s)                      state_nxt = START;
      START:      if (start_pt)                   state_nxt = sample ? IDLE : DATA;
      DATA:       if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:       if (bit_end)                    state_nxt = sample ? IDLE : BREAK_WAIT;
      BREAK_WAIT: if (rx_s)                       state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    take_bit = (state == DATA) && bit_end;
    stop_ok  = (state == STOP) && bit_end && sample;
    stop_bad = (state == STOP) && bit_end && !sample;
  end

  // The counter restarts on every state change and on each data-bit wrap,
  // so the bit spacing stays exactly CLKS_PER_BIT from the start-bit decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte_q     <= '0;
      rx_dv_q       <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      if (state_nxt != state || bit_end || state == IDLE || state == BREAK_WAIT)
        count <= '0;
      else
        count <= count + 1'b1;

      if (state == START)
        bit_idx <= '0;
      else if (take_bit)
        bit_idx <= bit_idx + 3'd1;

      if (take_bit)
        shreg[bit_idx] <= sample;

      if (stop_ok)
        rx_byte_q <= shreg;
      rx_dv_q       <= stop_ok;
      framing_err_q <= stop_bad;
    end
  end

  assign rx.RX_byte     = rx_byte_q;
  assign rx.RX_DV       = rx_dv_q;
  assign rx.framing_err = framing_err_q;
  assign rx.busy        = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and randomised line waveforms are compared cycle by cycle
// against a frame-level timing model derived from start detection, bit period and sample offsets.
module tb_uart_rx;

  localparam int C = 217;
  localparam int H = 108;
`ifdef UART_RX_MAJORITY_EN
  localparam int M = 1;
`else
  localparam int M = 0;
`endif
  localparam int N = 9*C + H + 4 + M;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C), .HALF_CLKS_PER_BIT(H)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       line_q[$];
  bit         exp_busy[], exp_dv[], exp_fe[];
  logic [7:0] dv_byte[];
  int         obs_dv_edge[$];
  logic [7:0] obs_byte[$];
  bit         obs_busy[];
  int         obs_fe_cnt;
  int         model_dv_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic v, input int n);
    repeat (n) line_q.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input int cpb, input logic stop_bit);
    add(1'b0, cpb);
    for (int k = 0; k < 8; k++) add(b[k], cpb);
    add(stop_bit, cpb);
  endtask

  // Line value presented at edge i (edge 1 is the first edge after the reset edge).
  function automatic logic rx_at(input int i);
    if (i < 1 || i > line_q.size()) return 1'b1;
    return line_q[i-1];
  endfunction

  // Value a sample decided at nominal edge d sees: the line two edges earlier (synchronizer).
  function automatic logic samp(input int d);
`ifdef UART_RX_MAJORITY_EN
    logic a, b, c;
    a = rx_at(d-3);
    b = rx_at(d-2);
    c = rx_at(d-1);
    return (a & b) | (a & c) | (b & c);
`else
    return rx_at(d-2);
`endif
  endfunction

  task automatic mark_busy(input int lo, input int hi);
    for (int x = lo; x <= hi && x < exp_busy.size(); x++) exp_busy[x] = 1'b1;
  endtask

  // Walk the line frame by frame: find the start edge t, then evaluate the start check,
  // the eight data samples and the stop sample at their spec offsets from t.
  task automatic build_model();
    int         L, ready, t, d, ds, u;
    logic [7:0] b;
    L        = line_q.size();
    exp_busy = new[L+1];
    exp_dv   = new[L+1];
    exp_fe   = new[L+1];
    dv_byte  = new[L+1];
    ready    = 1;
    forever begin
      t = ready;
      while (t <= L && rx_at(t) !== 1'b0) t++;
      if (t > L) break;
      d = t + H + 3;
      if (samp(d)) begin
        mark_busy(t+2, d+M-1);
        ready = d + M - 1;
        continue;
      end
      for (int k = 0; k < 8; k++) b[k] = samp(d + (k+1)*C);
      ds = d + 9*C;
      if (samp(ds)) begin
        mark_busy(t+2, ds+M-1);
        if (ds + M <= L) begin
          exp_dv[ds+M]  = 1'b1;
          dv_byte[ds+M] = b;
        end
        ready = ds + M - 1;
      end else begin
        if (ds + M <= L) exp_fe[ds+M] = 1'b1;
        u = ds + M - 1;
        while (u <= L && rx_at(u) !== 1'b1) u++;
        mark_busy(t+2, u+1);
        ready = u + 1;
      end
    end
  endtask

  task automatic run_line();
    int          L;
    logic [7:0]  cur;
    logic [10:0] o, e;
    L = line_q.size();
    build_model();
    obs_dv_edge.delete();
    obs_byte.delete();
    obs_fe_cnt   = 0;
    model_dv_cnt = 0;
    obs_busy     = new[L+1];
    rst           = 1'b1;
    bus.RX_serial = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs", {bus.busy, bus.RX_DV, bus.framing_err, bus.RX_byte}, '0);
    rst = 1'b0;
    cur = 8'h00;
    for (int i = 1; i <= L; i++) begin
      bus.RX_serial = line_q[i-1];
      @(posedge clk); #1;
      if (exp_dv[i]) begin
        cur = dv_byte[i];
        model_dv_cnt++;
      end
      e = {exp_busy[i], exp_dv[i], exp_fe[i], cur};
      o = {bus.busy, bus.RX_DV, bus.framing_err, bus.RX_byte};
      check($sformatf("cycle%0d{busy,dv,fe,byte}", i), 32'(o), 32'(e));
      obs_busy[i] = bus.busy;
      if (bus.RX_DV) begin
        obs_dv_edge.push_back(i);
        obs_byte.push_back(bus.RX_byte);
      end
      if (bus.framing_err) obs_fe_cnt++;
    end
    check("dv_count_vs_model", obs_dv_edge.size(), model_dv_cnt);
  endtask

  initial begin
    int pre_evt;
    int idx;
    bus.RX_serial = 1'b1;

    // 1: 0xA5 at nominal rate, latency N from the first low edge
    line_q.delete();
    add(1'b1, 40); add_frame(8'hA5, C, 1'b1); add(1'b1, 300);
    run_line();
    check("t1_dv_count", obs_dv_edge.size(), 1);
    check("t1_fe_count", obs_fe_cnt, 0);
    if (obs_dv_edge.size() == 1) begin
      check("t1_latency", obs_dv_edge[0] - 40, N);
      check("t1_byte", obs_byte[0], 8'hA5);
    end

    // 2: 50-clock glitch rejected at the half-bit check
    line_q.delete();
    add(1'b1, 20); add(1'b0, 50); add(1'b1, 300);
    run_line();
    check("t2_dv_count", obs_dv_edge.size(), 0);
    check("t2_fe_count", obs_fe_cnt, 0);
    idx = 0;
    for (int i = 1; i < obs_busy.size(); i++) if (obs_busy[i]) idx = i;
    check("t2_busy_within_115", 32'((idx - 20) < 115), 1);

    // 3: good 0x96, then 0x3C with low stop and a 3000-clock break
    line_q.delete();
    add(1'b1, 30); add_frame(8'h96, C, 1'b1); add(1'b1, 50);
    add_frame(8'h3C, C, 1'b0); add(1'b0, 3000); add(1'b1, 400);
    run_line();
    check("t3_fe_count", obs_fe_cnt, 1);
    check("t3_dv_count", obs_dv_edge.size(), 1);
    check("t3_byte_retained", dut.rx.RX_byte, 8'h96);
    idx = 30 + 10*C + 50 + 10*C + 3000;
    check("t3_busy_during_break", obs_busy[idx], 1);

    // 4: back-to-back 0x00/0xFF at -3% and +3% baud
    line_q.delete();
    add(1'b1, 30);
    add_frame(8'h00, 211, 1'b1); add_frame(8'hFF, 211, 1'b1); add(1'b1, 100);
    add_frame(8'h00, 223, 1'b1); add_frame(8'hFF, 223, 1'b1); add(1'b1, 300);
    run_line();
    check("t4_dv_count", obs_dv_edge.size(), 4);
    if (obs_byte.size() == 4) begin
      check("t4_byte0", obs_byte[0], 8'h00);
      check("t4_byte1", obs_byte[1], 8'hFF);
      check("t4_byte2", obs_byte[2], 8'h00);
      check("t4_byte3", obs_byte[3], 8'hFF);
    end

    // 5: reset midway through data bit 4 of 0x81, then 0x7E
    line_q.delete();
    add(1'b1, 20); add_frame(8'h81, C, 1'b1);
    pre_evt = 0;
    for (int i = 0; i < 20 + 5*C + H; i++) begin
      bus.RX_serial = line_q[i];
      @(posedge clk); #1;
      if (bus.RX_DV || bus.framing_err) pre_evt++;
    end
    check("t5_no_pre_reset_events", pre_evt, 0);
    line_q.delete();
    add(1'b0, 2); add(1'b1, 30); add_frame(8'h7E, C, 1'b1); add(1'b1, 300);
    run_line();
    check("t5_dv_count", obs_dv_edge.size(), 1);
    if (obs_byte.size() == 1) check("t5_byte", obs_byte[0], 8'h7E);

    // 6: 1-clock inverted glitch at the bit-3 sample point of 0x55
    line_q.delete();
    add(1'b1, 25); add_frame(8'h55, C, 1'b1); add(1'b1, 300);
    idx = (26 + H + 3 + 4*C) - 2;
    line_q[idx-1] = ~line_q[idx-1];
    run_line();
    check("t6_dv_count", obs_dv_edge.size(), 1);
`ifdef UART_RX_MAJORITY_EN
    if (obs_byte.size() == 1) check("t6_byte_majority", obs_byte[0], 8'h55);
`else
    if (obs_byte.size() == 1) check("t6_byte_single", obs_byte[0], 8'h5D);
`endif

    // 7: random bytes, baud skew, gaps and occasional bad stop bits
    line_q.delete();
    add(1'b1, 20);
    for (int f = 0; f < 8; f++) begin
      add_frame(8'($urandom), $urandom_range(223, 211), ($urandom_range(7, 0) != 0));
      add(1'b1, $urandom_range(40, 0));
    end
    add(1'b1, 400);
    run_line();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive counterpart to the team's UART transmitter.
- Oversamples RX_serial with the system clock and samples each bit at mid-period.
- Presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the command/host-link logic of the falling-sand design.

Parameters:
- CLKS_PER_BIT, 217, clocks per bit (clock rate / baud rate); must be ≥ 4.
- HALF_CLKS_PER_BIT, 108, mid-bit sample offset; must satisfy 1 ≤ HALF_CLKS_PER_BIT ≤ CLKS_PER_BIT-2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- RX_serial  in  1  asynchronous serial line; idle high
- RX_byte  out  8  last correctly framed byte
- RX_DV  out  1  one-cycle pulse; RX_byte is valid and newly updated
- framing_err  out  1  one-cycle pulse; stop bit sampled low
- busy  out  1  high while not in IDLE

Behaviour:
- Reset: clk and rst as decided: reset rst, synchronous, active-high; clock clk. Reset forces all of the following, overriding any frame in progress:
  - state=IDLE, count=0, bit index=0, shift register=0
  - RX_byte=0x00, RX_DV=0, framing_err=0, busy=0
  - both synchronizer flops=1
- Input path:
  - RX_serial passes through a 2-flop synchronizer to form rx_s.
  - Only rx_s is used internally.
- States and transitions:
  - IDLE: count=0. On rx_s==0, go to START with count=0.
  - START: count increments each cycle. At count==HALF_CLKS_PER_BIT, sample rx_s.
    - Sample 0: go to DATA with count=0 and bit index=0.
    - Sample 1: glitch. Go to IDLE with no output pulse.
  - DATA: count runs 0..CLKS_PER_BIT-1 and wraps to 0.
    - At each wrap, sample rx_s into shift-register bit[index] (LSB first), then increment the index.
    - Bit 7 is sampled exactly CLKS_PER_BIT after bit 6. After bit 7 is sampled, go to STOP with count=0.
  - STOP: at count==CLKS_PER_BIT-1, sample rx_s.
    - Sample 1: on the next cycle, RX_byte is loaded from the shift register and RX_DV=1 for exactly that one cycle. Then go to IDLE.
    - Sample 0: framing_err=1 for one cycle and RX_byte is unchanged. Then go to BREAK_WAIT.
  - BREAK_WAIT: hold until rx_s==1, then go to IDLE. A line held low (break) yields exactly one framing_err, never repeated frames.
- Sample-point timing: data bit k and the stop bit are sampled at HALF_CLKS_PER_BIT + (k+1)*CLKS_PER_BIT counts after start detection. The stop bit is k=8.
- Latency:
  - Count from the first clk edge at which RX_serial is low.
  - RX_DV is high in cycle N = 9*CLKS_PER_BIT + HALF_CLKS_PER_BIT + 4.
  - With defaults, N = 2065.
- Back-to-back frames: the return to IDLE happens half a bit before the nominal stop-bit end, so a start bit directly following the stop bit is detected.
- RX_DV and framing_err are never high in the same cycle.
- RX_serial activity during a frame other than at sample points is ignored.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN
- Defined:
  - Each sample (start, data, stop) is the 2-of-3 majority of rx_s at sample point -1, 0 and +1 clock.
  - The decision is registered at sample point +1.
  - All subsequent timing shifts by +1 cycle (N=2066 with defaults).
  - The bit-period spacing is unchanged.
- Undefined: single sample at the sample point, as above.

Test Plan:
1. Send 0xA5 8N1 at exactly 217 clk/bit, then idle high -> RX_DV pulses once for one cycle at cycle 2065 (2066 with majority); RX_byte=0xA5; framing_err stays 0.
2. Low glitch of 50 clocks on an idle line -> START rejects at the half-bit check; no RX_DV, no framing_err; busy returns to 0 within 115 cycles.
3. Frame 0x3C with the stop bit driven low, then the line held low for 3000 clocks -> exactly one framing_err pulse; RX_byte retains its previous value; busy stays high until the line returns high.
4. Back-to-back 0x00 then 0xFF with no idle gap, and baud skewed ±3% (211 and 223 clk/bit) -> two RX_DV pulses with RX_byte 0x00 then 0xFF.
5. Assert rst for 1 cycle midway through data bit 4 of 0x81, then send 0x7E -> RX_DV only for 0x7E; no partial byte; all outputs are 0 during the reset cycle's aftermath.
6. With UART_RX_MAJORITY_EN, a 1-clock inverted glitch exactly at the bit-3 sample point of 0x55 -> RX_byte=0x55. Without the macro -> RX_byte=0x5D.
